// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage with stall buffering and branch/exception redirect
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   stall[5:0]            stall vector, bit 0 holds the PC/fetch
//   branch_flag/_target   taken branch/jump from ID and its target
//   exc_flag/_target      exception/flush redirect and handler address
//   imem_req/_addr        fetch request and address to instruction memory
//   imem_rdata/_ready     instruction word and its valid/accept strobe
//   IF_PC/IF_instruction  delivered instruction and its address (0 = bubble)
//   fetch_stall_req       asks the stall controller to freeze the front end
// Build option: IF_DELAY_SLOT_EN delivers the word fetched alongside a taken branch.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        exc_flag,
    input  logic [31:0] exc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_instruction,
    output logic        fetch_stall_req
);
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
    state_t      state;
    logic [31:0] pc, ibuf, tgt, raddr;
    logic        pend, redirect, squash, ds, unused_stall;
    assign redirect = exc_flag | branch_flag;
    assign raddr = exc_flag ? exc_target : branch_target;
    assign unused_stall = ^stall[5:1];
`ifdef IF_DELAY_SLOT_EN
    // a taken branch keeps its companion word; only exceptions squash it
    assign ds = branch_flag & ~exc_flag;
    assign squash = exc_flag;
`else
    assign ds = 1'b0;
    assign squash = redirect;
`endif
    // pend/tgt remember a delay-slot branch target while its word sits in HOLD;
    // tgt also keeps the redirect address while an abandoned fetch drains
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            ibuf  <= '0;
            tgt   <= '0;
            pend  <= 1'b0;
            state <= FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        if (squash) pc <= raddr;
                        else if (stall[0]) begin
                            ibuf  <= imem_rdata;
                            pend  <= ds;
                            tgt   <= ds ? branch_target : tgt;
                            state <= HOLD;
                        end else pc <= ds ? branch_target : pc + 32'd4;
                    end else if (redirect) begin
                        tgt   <= raddr;
                        state <= DISCARD;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= raddr;
                        state <= FETCH;
                    end else if (!stall[0]) begin
                        pc    <= pend ? tgt : pc + 32'd4;
                        state <= FETCH;
                    end
                end
                DISCARD: begin
                    if (redirect) tgt <= raddr;
                    if (imem_ready) begin
                        pc    <= redirect ? raddr : tgt;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
    always_comb begin
        imem_req        = ~reset & (state != HOLD);
        imem_addr       = pc;
        IF_PC           = pc;
        IF_instruction  = reset ? 32'h0 :
                          (state == FETCH) ? ((imem_ready & ~stall[0] & ~squash) ? imem_rdata : 32'h0) :
                          (state == HOLD && !redirect) ? ibuf : 32'h0;
        fetch_stall_req = ~reset & ((state == DISCARD) | ((state == FETCH) & ~imem_ready));
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and randomized checks of if_fetch_unit against a behavioural model
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  stall;
    logic        branch_flag, exc_flag, imem_ready;
    logic [31:0] branch_target, exc_target;
    logic        imem_req, fetch_stall_req;
    logic [31:0] imem_addr, imem_rdata, IF_PC, IF_instruction;
    int n_checks = 0;
    int n_fail = 0;
`ifdef IF_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif
    always #5 clk = ~clk;
    // memory holds address|1 at every word address
    assign imem_rdata = imem_addr | 32'h1;
    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .exc_flag(exc_flag), .exc_target(exc_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .IF_PC(IF_PC), .IF_instruction(IF_instruction),
        .fetch_stall_req(fetch_stall_req)
    );
    task automatic idle();
        stall = '0; branch_flag = 0; exc_flag = 0; imem_ready = 1;
        branch_target = '0; exc_target = '0;
    endtask
    task automatic do_reset();
        idle();
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask
    task automatic test_reset();
        idle();
        reset = 1;
        @(negedge clk); #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
        n_checks++; if (IF_instruction !== 32'h0) begin n_fail++; $display("FAIL reset_ins got %h want 0", IF_instruction); end
        n_checks++; if (fetch_stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_fsr got %b want 0", fetch_stall_req); end
        n_checks++; if (IF_PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", IF_PC); end
        reset = 0; #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req got %b/%h want 1/0", imem_req, imem_addr); end
    endtask
    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (IF_PC !== 32'(4*i) || IF_instruction !== 32'(4*i+1)) begin n_fail++; $display("FAIL stream%0d got %h/%h want %h/%h", i, IF_PC, IF_instruction, 4*i, 4*i+1); end
            @(negedge clk);
        end
    endtask
    task automatic test_stall();
        do_reset();
        repeat (2) @(negedge clk);
        stall = 6'h1; #1;
        n_checks++; if (IF_PC !== 32'h8 || IF_instruction !== 32'h0) begin n_fail++; $display("FAIL stall_entry got %h/%h want 8/0", IF_PC, IF_instruction); end
        repeat (2) begin
            @(negedge clk); #1;
            n_checks++; if (imem_req !== 1'b0 || IF_instruction !== 32'h9 || IF_PC !== 32'h8 || fetch_stall_req !== 1'b0) begin n_fail++; $display("FAIL stall_hold got req=%b %h/%h want 0 8/9", imem_req, IF_PC, IF_instruction); end
        end
        @(negedge clk);
        stall = 6'h0; #1;
        n_checks++; if (IF_instruction !== 32'h9 || IF_PC !== 32'h8) begin n_fail++; $display("FAIL stall_release got %h/%h want 8/9", IF_PC, IF_instruction); end
        @(negedge clk); #1;
        n_checks++; if (IF_PC !== 32'hC || IF_instruction !== 32'hD) begin n_fail++; $display("FAIL stall_next got %h/%h want c/d", IF_PC, IF_instruction); end
    endtask
    task automatic test_wait();
        do_reset();
        @(negedge clk);
        imem_ready = 0;
        repeat (2) begin
            #1;
            n_checks++; if (fetch_stall_req !== 1'b1 || IF_instruction !== 32'h0 || imem_addr !== 32'h4 || imem_req !== 1'b1) begin n_fail++; $display("FAIL wait got fsr=%b addr=%h ins=%h want 1 4 0", fetch_stall_req, imem_addr, IF_instruction); end
            @(negedge clk);
        end
        imem_ready = 1; #1;
        n_checks++; if (IF_instruction !== 32'h5 || IF_PC !== 32'h4 || fetch_stall_req !== 1'b0) begin n_fail++; $display("FAIL wait_done got %h/%h fsr=%b want 4/5 0", IF_PC, IF_instruction, fetch_stall_req); end
    endtask
    task automatic test_discard();
        do_reset();
        @(negedge clk);
        imem_ready = 0; branch_flag = 1; branch_target = 32'h100; #1;
        n_checks++; if (fetch_stall_req !== 1'b1 || IF_instruction !== 32'h0) begin n_fail++; $display("FAIL disc_entry got fsr=%b ins=%h want 1 0", fetch_stall_req, IF_instruction); end
        @(negedge clk);
        branch_flag = 0; #1;
        n_checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b1 || fetch_stall_req !== 1'b1 || IF_instruction !== 32'h0) begin n_fail++; $display("FAIL disc_wait got addr=%h req=%b fsr=%b ins=%h", imem_addr, imem_req, fetch_stall_req, IF_instruction); end
        @(negedge clk);
        imem_ready = 1; #1;
        n_checks++; if (IF_instruction !== 32'h0 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL disc_drop got addr=%h ins=%h want 4 0", imem_addr, IF_instruction); end
        @(negedge clk); #1;
        n_checks++; if (imem_addr !== 32'h100 || IF_instruction !== 32'h101) begin n_fail++; $display("FAIL disc_target got addr=%h ins=%h want 100 101", imem_addr, IF_instruction); end
    endtask
    task automatic test_both();
        do_reset();
        @(negedge clk);
        branch_flag = 1; branch_target = 32'h100; exc_flag = 1; exc_target = 32'h180; #1;
        n_checks++; if (IF_instruction !== 32'h0) begin n_fail++; $display("FAIL both_bubble got %h want 0", IF_instruction); end
        @(negedge clk);
        idle(); #1;
        n_checks++; if (imem_addr !== 32'h180 || IF_instruction !== 32'h181) begin n_fail++; $display("FAIL both_target got addr=%h ins=%h want 180 181", imem_addr, IF_instruction); end
    endtask
    task automatic test_delay_slot();
        logic [31:0] want;
        do_reset();
        repeat (2) @(negedge clk);
        branch_flag = 1; branch_target = 32'h40; #1;
        want = DS ? 32'h9 : 32'h0;
        n_checks++; if (IF_PC !== 32'h8 || IF_instruction !== want) begin n_fail++; $display("FAIL delay_slot got %h/%h want 8/%h", IF_PC, IF_instruction, want); end
        @(negedge clk);
        idle(); #1;
        n_checks++; if (IF_PC !== 32'h40 || IF_instruction !== 32'h41) begin n_fail++; $display("FAIL branch_target got %h/%h want 40/41", IF_PC, IF_instruction); end
    endtask
    function automatic logic [31:0] rand_target();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(3))
            0: rand_target = 32'hFFFF_FFF8;
            1: rand_target = 32'hFFFF_FFFC;
            default: rand_target = {r[31:2], 2'b00};
        endcase
    endfunction
    // model: program counter plus "holding a word" / "draining an abandoned fetch" flags
    task automatic test_random();
        logic [31:0] m_pc, m_word, m_tgt, m_after, ra, e_pc, e_ins;
        logic        m_held, m_drop, redir, e_req, e_fsr;
        do_reset();
        m_pc = 32'h0; m_held = 0; m_drop = 0; m_tgt = 0; m_word = 0; m_after = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(99) == 0);
            stall = 6'($urandom);
            stall[0] = ($urandom_range(3) == 0);
            imem_ready = ($urandom_range(3) != 0);
            branch_flag = ($urandom_range(9) == 0);
            exc_flag = ($urandom_range(19) == 0);
            branch_target = rand_target();
            exc_target = rand_target();
            #1;
            redir = branch_flag | exc_flag;
            ra = exc_flag ? exc_target : branch_target;
            e_pc = m_pc; e_ins = 0; e_req = 0; e_fsr = 0;
            if (reset) begin
                m_pc = 32'h0; m_held = 0; m_drop = 0;
            end else if (m_held) begin
                e_ins = redir ? 32'h0 : m_word;
                if (redir) begin m_pc = ra; m_held = 0; end
                else if (!stall[0]) begin m_pc = m_after; m_held = 0; end
            end else if (m_drop) begin
                e_req = 1; e_fsr = 1;
                if (redir) m_tgt = ra;
                if (imem_ready) begin m_pc = m_tgt; m_drop = 0; end
            end else begin
                e_req = 1; e_fsr = ~imem_ready;
                if (!imem_ready) begin
                    if (redir) begin m_drop = 1; m_tgt = ra; end
                end else if (exc_flag || (branch_flag && !DS)) m_pc = ra;
                else if (stall[0]) begin
                    m_held = 1; m_word = m_pc | 32'h1;
                    m_after = branch_flag ? branch_target : m_pc + 32'd4;
                end else begin
                    e_ins = m_pc | 32'h1;
                    m_pc = branch_flag ? branch_target : m_pc + 32'd4;
                end
            end
            n_checks++; if (imem_req !== e_req || (e_req && imem_addr !== e_pc)) begin n_fail++; $display("FAIL rand_req c=%0d got %b/%h want %b/%h", c, imem_req, imem_addr, e_req, e_pc); end
            n_checks++; if (IF_PC !== e_pc || IF_instruction !== e_ins) begin n_fail++; $display("FAIL rand_out c=%0d got %h/%h want %h/%h", c, IF_PC, IF_instruction, e_pc, e_ins); end
            n_checks++; if (fetch_stall_req !== e_fsr) begin n_fail++; $display("FAIL rand_fsr c=%0d got %b want %b", c, fetch_stall_req, e_fsr); end
            @(negedge clk);
        end
    endtask
    initial begin
        idle();
        reset = 1;
        repeat (2) @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_wait();
        test_discard();
        test_both();
        test_delay_slot();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, fetch address loaded by reset.
REQ-002 SHALL have ports, clock and reset first: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have stall  in  6  stall vector from the stall controller; bit 0 = PC/fetch hold.
REQ-004 SHALL have branch_flag  in  1  ID-stage branch/jump taken; branch_target  in  32  its target.
REQ-005 SHALL have exc_flag  in  1  exception/flush redirect; exc_target  in  32  handler address.
REQ-006 SHALL have imem_req  out  1  fetch request; imem_addr  out  32  fetch address; imem_rdata  in  32  instruction word; imem_ready  in  1  rdata valid / request accepted this cycle.
REQ-007 SHALL have IF_PC  out  32  address of delivered instruction; IF_instruction  out  32  instruction word, 0 = bubble.
REQ-008 SHALL have fetch_stall_req  out  1  request to the stall controller to freeze the front end.

Function
REQ-009 SHALL hold the PC register pc, instruction buffer buf, saved target tgt, and state in {FETCH, HOLD, DISCARD}.
REQ-010 SHALL define redirect = exc_flag | branch_flag, redirect address = exc_target if exc_flag else branch_target (exception wins).
REQ-011 SHALL in FETCH drive imem_req=1, imem_addr=pc; imem_addr stays stable until imem_ready=1.
REQ-012 SHALL in FETCH with imem_ready=1, no redirect, stall[0]=0: output IF_PC=pc, IF_instruction=imem_rdata in the same cycle, pc<=pc+4 (mod 2^32, wrap 32'hFFFF_FFFC->0), stay FETCH; zero wait states give one instruction per cycle.
REQ-013 SHALL in FETCH with imem_ready=1, no redirect, stall[0]=1: buf<=imem_rdata, pc unchanged, ->HOLD; output bubble this cycle.
REQ-014 SHALL in FETCH with imem_ready=1 and redirect: pc<=redirect address, stay FETCH, output bubble (delay-slot exception in Configuration).
REQ-015 SHALL in FETCH with imem_ready=0: output bubble, fetch_stall_req=1; on redirect tgt<=redirect address and ->DISCARD, else stay.
REQ-016 SHALL in HOLD drive imem_req=0, IF_PC=pc, IF_instruction=buf; redirect -> pc<=redirect address, output bubble, ->FETCH; else stall[0]=0 -> pc<=pc+4, ->FETCH; else stay.
REQ-017 SHALL in DISCARD keep imem_req=1, imem_addr=old pc, output bubble, fetch_stall_req=1; further redirects overwrite tgt; on imem_ready=1 drop rdata, pc<=tgt (or the redirect address if a redirect arrives in that cycle), ->FETCH.
REQ-018 SHALL give redirect priority over stall[0] in every state.
REQ-019 SHALL output bubble as IF_PC=pc, IF_instruction=32'h0000_0000.
REQ-020 SHALL keep fetch_stall_req=0 in HOLD and in FETCH when imem_ready=1.

Reset
REQ-021 SHALL while reset=1 load pc<=RESET_PC, buf<=0, tgt<=0, state<=FETCH, and force imem_req=0, IF_instruction=0, fetch_stall_req=0.
REQ-022 SHALL issue the first request, imem_addr=RESET_PC, in the first cycle after reset falls.
REQ-023 SHALL let reset during DISCARD or HOLD abandon the outstanding request and buffered word with no delivery.

Configuration
REQ-024 SHALL support macro IF_DELAY_SLOT_EN: defined -> in FETCH with imem_ready=1 and branch_flag=1, exc_flag=0, the fetched word (delay slot) is delivered per REQ-012 with pc<=branch_target, or buffered per REQ-013 if stall[0]=1 with pc<=branch_target on leaving HOLD; undefined -> REQ-014 squash applies; exceptions always squash.

Verification
REQ-025 SHALL pass: reset, imem_ready tied 1, rdata=addr|1 -> IF_PC 0,4,8 on consecutive cycles, IF_instruction 1,5,9.
REQ-026 SHALL pass: stall[0]=1 for 3 cycles at pc=8 -> HOLD, imem_req=0, IF_instruction=buf=9 held; release -> next delivery pc=12.
REQ-027 SHALL pass: imem_ready low 2 cycles at pc=4 -> fetch_stall_req=1, bubbles, imem_addr=4 stable; third cycle delivers word 5.
REQ-028 SHALL pass: branch_flag, target 0x100, while ready low at pc=4 -> DISCARD, word at 4 dropped, next imem_addr=0x100.
REQ-029 SHALL pass: branch_flag and exc_flag same cycle, targets 0x100/0x180 -> next imem_addr=0x180, bubble output.
REQ-030 SHALL pass: branch target 0x40 at pc=8, ready=1 -> with IF_DELAY_SLOT_EN IF_PC=8 delivered then 0x40; without, bubble then 0x40.
